siso_shift_ctrl: RTL and testbench

//  Sequencer for a DEPTH-stage SISO shift register (enb/inp/out interface). Accepts a parallel word via

---
 rtl/siso_ctrl_pkg.sv | 17 +
 rtl/siso_ctrl_capture.sv | 37 +++
 rtl/siso_shift_ctrl.sv | 164 ++++++++++++++++
 tb/tb_siso_shift_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/siso_ctrl_pkg.sv
// Shared types and helpers for the SISO shift-register sequencer.
// Optional loop-back check build macro: SISO_CTRL_LOOPCHK_EN (used in siso_shift_ctrl).
package siso_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Bits needed for a shift counter that reaches width+depth.
    function automatic int cnt_w(input int width, input int depth);
        return $clog2(width + depth + 1);
    endfunction

endpackage

// File: rtl/siso_ctrl_capture.sv
// Right-shifting capture register: each enabled edge pushes din into the MSB,
// so after WIDTH captures the first bit received sits in bit 0.
module siso_ctrl_capture
    import siso_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    generate
        if (WIDTH == 1) begin : g_single
            // Single-bit word: the register is just the last captured bit.
            always_ff @(posedge clk) begin
                if (rst) begin
                    q <= '0;
                end else if (en) begin
                    q <= din;
                end
            end
        end else begin : g_multi
            // Shift right, new bit enters at the MSB.
            always_ff @(posedge clk) begin
                if (rst) begin
                    q <= '0;
                end else if (en) begin
                    q <= {din, q[WIDTH-1:1]};
                end
            end
        end
    endgenerate

endmodule

// File: rtl/siso_shift_ctrl.sv
// Sequencer for a DEPTH-stage SISO shift register. Takes a parallel word on
// tx_*, shifts it LSB-first into the chain, flushes it with FILL bits and
// rebuilds the word coming out of ser_out, presented on rx_* for one cycle.
// Build macro SISO_CTRL_LOOPCHK_EN adds chk_err (received word != sent word).
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | tx_ready high, waiting for tx_valid
//   SHIFT | driving word bits 0..WIDTH-1 onto ser_inp
//   FLUSH | driving FILL for DEPTH shifts to push the word out of the chain
//   DONE  | one-cycle rx_valid with the recovered word, back to IDLE
module siso_shift_ctrl
    import siso_ctrl_pkg::*;
#(
    parameter int   WIDTH = 8,
    parameter int   DEPTH = 4,
    parameter logic FILL  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             pause,
    output logic             ser_enb,
    output logic             ser_inp,
    input  logic             ser_out,
    output logic             rx_valid,
    output logic [WIDTH-1:0] rx_data,
    output logic             busy
`ifdef SISO_CTRL_LOOPCHK_EN
    ,
    output logic             chk_err
`endif
);

    localparam int CW = cnt_w(WIDTH, DEPTH);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
    localparam logic [CW-1:0] CNT_DEPTH    = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_TX_LAST  = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ALL_LAST = CW'(WIDTH + DEPTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_d;
    logic [WIDTH-1:0] rx_sr;
    logic [WIDTH-1:0] rx_hold_q;
    logic [IW-1:0]    bit_idx;
    logic             capture_en;

    // In SHIFT the counter never exceeds WIDTH-1, so its low bits select the word bit.
    assign bit_idx = cnt_q[IW-1:0];

    // Next-state, counter advance and serial/handshake outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        tx_ready = 1'b0;
        ser_enb  = 1'b0;
        ser_inp  = 1'b0;
        rx_valid = 1'b0;
        busy     = 1'b1;
        case (state_q)
            IDLE: begin
                tx_ready = 1'b1;
                busy     = 1'b0;
                if (tx_valid) begin
                    word_d  = tx_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                ser_enb = ~pause;
                ser_inp = word_q[bit_idx];
                if (!pause) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_TX_LAST) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                ser_enb = ~pause;
                ser_inp = FILL;
                if (!pause) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_ALL_LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                rx_valid = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, shift counter and latched tx word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
        end
    end

    // The first DEPTH shifts only fill the chain; later shifts each expose one word bit on ser_out.
    assign capture_en = ser_enb && (cnt_q >= CNT_DEPTH);

    siso_ctrl_capture #(
        .WIDTH (WIDTH)
    ) u_capture (
        .clk (clk),
        .rst (rst),
        .en  (capture_en),
        .din (ser_out),
        .q   (rx_sr)
    );

    // Keep the delivered word stable while the next word refills the capture register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_hold_q <= '0;
        end else if (state_q == DONE) begin
            rx_hold_q <= rx_sr;
        end
    end

    assign rx_data = (state_q == DONE) ? rx_sr : rx_hold_q;

`ifdef SISO_CTRL_LOOPCHK_EN
    logic chk_now;
    logic chk_hold_q;

    assign chk_now = (rx_sr != word_q);

    // Hold the loop-back verdict alongside rx_data until the next word completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_hold_q <= 1'b0;
        end else if (state_q == DONE) begin
            chk_hold_q <= chk_now;
        end
    end

    assign chk_err = (state_q == DONE) ? chk_now : chk_hold_q;
`endif

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// Bench for siso_shift_ctrl: WIDTH=8/DEPTH=4 instance plus a WIDTH=2/DEPTH=4
// instance, each closed through a behavioural SISO chain on ser_*.
module tb_siso_shift_ctrl;

    localparam int W   = 8;
    localparam int D   = 4;
    localparam int TOT = W + D;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       pause = 1'b0;
    logic       tx_ready, ser_enb, ser_inp, ser_out, rx_valid, busy;
    logic [7:0] rx_data;

    logic       tx_valid2 = 1'b0;
    logic [1:0] tx_data2 = 2'b00;
    logic       pause2 = 1'b0;
    logic       tx_ready2, ser_enb2, ser_inp2, ser_out2, rx_valid2, busy2;
    logic [1:0] rx_data2;

`ifdef SISO_CTRL_LOOPCHK_EN
    logic chk_err;
    logic chk_err2;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    siso_shift_ctrl #(.WIDTH(8), .DEPTH(4), .FILL(1'b0)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .pause    (pause),
        .ser_enb  (ser_enb),
        .ser_inp  (ser_inp),
        .ser_out  (ser_out),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .busy     (busy)
`ifdef SISO_CTRL_LOOPCHK_EN
        ,
        .chk_err  (chk_err)
`endif
    );

    siso_shift_ctrl #(.WIDTH(2), .DEPTH(4), .FILL(1'b0)) dut2 (
        .clk      (clk),
        .rst      (rst),
        .tx_valid (tx_valid2),
        .tx_ready (tx_ready2),
        .tx_data  (tx_data2),
        .pause    (pause2),
        .ser_enb  (ser_enb2),
        .ser_inp  (ser_inp2),
        .ser_out  (ser_out2),
        .rx_valid (rx_valid2),
        .rx_data  (rx_data2),
        .busy     (busy2)
`ifdef SISO_CTRL_LOOPCHK_EN
        ,
        .chk_err  (chk_err2)
`endif
    );

    // Behavioural 4-stage SISO chains; stage 2 of the first can be forced stuck-at-0.
    logic [3:0] chain  = 4'h0;
    logic [3:0] chain2 = 4'h0;
    bit         stuck  = 1'b0;

    always @(posedge clk) begin
        if (rst) chain <= 4'h0;
        else if (ser_enb) chain <= {chain[2:0], ser_inp} & (stuck ? 4'b1011 : 4'b1111);
    end
    always @(posedge clk) begin
        if (ser_enb2) chain2 <= {chain2[2:0], ser_inp2};
    end
    assign ser_out  = chain[3];
    assign ser_out2 = chain2[3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One word through the 8-bit instance. pmode: 0 none, 1 random pause, 2 scripted pause.
    // hold keeps tx_valid high with nd during busy; pre_acc means the word was already accepted.
    task automatic send(input logic [7:0] d, input int pmode, input bit hold,
                        input logic [7:0] nd, input bit pre_acc, input int abort_at);
        bit         exp_bits[$];
        logic [7:0] t = d;
        logic [7:0] exp_rx;
        int         idx = 0;
        int         npause = 0;
        bit         done = 1'b0;
        for (int i = 0; i < W; i++) begin
            exp_bits.push_back(t[0]);
            t = t >> 1;
        end
        for (int i = 0; i < D; i++) exp_bits.push_back(1'b0);
        exp_rx = stuck ? 8'h00 : d;

        if (!pre_acc) begin
            tx_valid = 1'b1;
            tx_data  = d;
            pause    = 1'b0;
            @(negedge clk);
            check("accept_ready", tx_ready, 1);
            @(posedge clk); #1;
        end
        if (hold) tx_data = nd;
        else tx_valid = 1'b0;

        for (int c = 1; c <= 80 && !done; c++) begin
            case (pmode)
                1:       pause = ($urandom_range(0, 2) == 0);
                2:       pause = (c >= 4 && c <= 6) || c == 14 || c == 15;
                default: pause = 1'b0;
            endcase
            if (abort_at >= 0 && idx == abort_at) begin
                rst   = 1'b1;
                pause = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                check("abort_ready", tx_ready, 1);
                check("abort_busy", busy, 0);
                check("abort_enb", ser_enb, 0);
                check("abort_rxv", rx_valid, 0);
                check("abort_rxdata", rx_data, 0);
                for (int k = 0; k < TOT + 2; k++) begin
                    @(posedge clk); #1;
                    @(negedge clk);
                    check("abort_no_rxv", rx_valid, 0);
                end
                @(posedge clk); #1;
                return;
            end
            @(negedge clk);
            check("busy", busy, 1);
            check("ready_busy", tx_ready, 0);
            if (idx < TOT) begin
                check("ser_enb", ser_enb, !pause);
                check("rxv_early", rx_valid, 0);
                if (pause) npause++;
                else begin
                    check("ser_inp", ser_inp, exp_bits[idx]);
                    idx++;
                end
            end else begin
                check("rxv", rx_valid, 1);
                check("latency", c, TOT + 1 + npause);
                check("rx_data", rx_data, exp_rx);
                check("enb_done", ser_enb, 0);
`ifdef SISO_CTRL_LOOPCHK_EN
                check("chk_err", chk_err, (exp_rx != d));
`endif
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        check("completed", done, 1);
        pause = 1'b0;
        @(negedge clk);
        check("rxv_pulse", rx_valid, 0);
        check("ready_back", tx_ready, 1);
        check("busy_clr", busy, 0);
        check("rx_hold", rx_data, exp_rx);
`ifdef SISO_CTRL_LOOPCHK_EN
        check("chk_hold", chk_err, (exp_rx != d));
`endif
        @(posedge clk); #1;
    endtask

    // One word through the 2-bit instance, no pause.
    task automatic send2(input logic [1:0] d);
        bit exp_bits[$];
        int idx = 0;
        bit done = 1'b0;
        exp_bits.push_back(d[0]);
        exp_bits.push_back(d[1]);
        for (int i = 0; i < D; i++) exp_bits.push_back(1'b0);
        tx_valid2 = 1'b1;
        tx_data2  = d;
        @(negedge clk);
        check("w2_ready", tx_ready2, 1);
        @(posedge clk); #1;
        tx_valid2 = 1'b0;
        for (int c = 1; c <= 30 && !done; c++) begin
            @(negedge clk);
            check("w2_busy", busy2, 1);
            if (idx < 2 + D) begin
                check("w2_enb", ser_enb2, 1);
                check("w2_ser_inp", ser_inp2, exp_bits[idx]);
                check("w2_rxv_early", rx_valid2, 0);
                idx++;
            end else begin
                check("w2_rxv", rx_valid2, 1);
                check("w2_latency", c, 2 + D + 1);
                check("w2_rx_data", rx_data2, d);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        check("w2_completed", done, 1);
        @(negedge clk);
        check("w2_rxv_pulse", rx_valid2, 0);
        check("w2_ready_back", tx_ready2, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_ready", tx_ready, 1);
        check("rst_enb", ser_enb, 0);
        check("rst_inp", ser_inp, 0);
        check("rst_rxv", rx_valid, 0);
        check("rst_rxdata", rx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_ready2", tx_ready2, 1);
        check("rst_rxdata2", rx_data2, 0);
`ifdef SISO_CTRL_LOOPCHK_EN
        check("rst_chk", chk_err, 0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;

        send(8'hA5, 0, 1'b0, 8'h00, 1'b0, -1);
        send(8'h3C, 2, 1'b0, 8'h00, 1'b0, -1);
        send(8'hFF, 0, 1'b1, 8'h01, 1'b0, -1);
        send(8'h01, 0, 1'b0, 8'h00, 1'b1, -1);
        send(8'h5A, 0, 1'b0, 8'h00, 1'b0, 6);
        send(8'h81, 0, 1'b0, 8'h00, 1'b0, -1);

        stuck = 1'b1;
        send(8'hFF, 0, 1'b0, 8'h00, 1'b0, -1);
        stuck = 1'b0;
        send(8'h0F, 0, 1'b0, 8'h00, 1'b0, -1);

        repeat (6) send(8'($urandom), 1, 1'b0, 8'h00, 1'b0, -1);

        send2(2'b10);
        repeat (3) send2(2'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
